machine_timer: RTL and testbench
================================

Name: machine_timer

Overview:
- Memory-mapped RISC-V machine timer (mtime/mtimecmp) feeding the core's `timer_interrupt` output.
- Sits on the core's data bus beside the GPIO and tohost peripherals.
- Decodes word accesses from the load/store unit and maintains a 64-bit free-running counter with a prescaler.
- Drives a level interrupt whenever mtime >= mtimecmp.

Parameters:
- BASE_ADDR, 32'h0200_4000, byte base address of the 16-byte register window.
- PRESCALE, 1, clk cycles per mtime increment; legal range 1..65535.
- RESET_CMP, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp, so no interrupt fires after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- bus_sel  in  1  access request to this peripheral (address already range-decoded upstream)
- bus_we  in  1  1 = write, 0 = read; sampled when bus_sel=1
- bus_addr  in  32  byte address; only bits [3:2] are decoded, bits [1:0] are ignored
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data; valid while bus_rvalid=1
- bus_rvalid  out  1  one-cycle pulse, 1 cycle after an accepted read
- timer_interrupt  out  1  level interrupt, registered

Behaviour:
- Register map (offset = bus_addr[3:2]):
  - 0: mtime[31:0]
  - 1: mtime[63:32]
  - 2: mtimecmp[31:0]
  - 3: mtimecmp[63:32]
- Reset (rst=0, asynchronous): mtime=0, prescale counter=0, mtimecmp=RESET_CMP, bus_rdata=0, bus_rvalid=0, timer_interrupt=0. Release is synchronous to clk edges.
- Prescaler:
  - pcnt counts 0..PRESCALE-1.
  - tick=1 in the cycle pcnt==PRESCALE-1; pcnt then wraps to 0.
  - PRESCALE=1 gives tick every cycle.
- mtime increments by 1 on tick, with full 64-bit carry; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Writes (bus_sel & bus_we) take effect at the next clk edge; every write is full-word (32-bit).
  - A write to an mtime half replaces that half. In the same cycle the tick increment is discarded for the whole 64-bit value: software write wins, and the other half holds.
  - Writing mtime does not reset pcnt.
  - A write to an mtimecmp half replaces only that half.
- Reads (bus_sel & ~bus_we):
  - bus_rdata is registered from the selected register's pre-edge value; bus_rvalid=1 for exactly one cycle. Latency is 1.
  - bus_rdata holds its last value when bus_rvalid=0.
  - No ready/stall: every access is accepted, including back-to-back accesses.
  - Reading mtime_hi does not latch mtime_lo; software performs the hi/lo/hi retry.
- Interrupt:
  - timer_interrupt <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare, evaluated on the post-update values and registered.
  - Result: it asserts in the same cycle the matching mtime value becomes visible, and deasserts 1 cycle after a write raises mtimecmp above mtime.
  - It remains asserted while the condition holds; there is no clear-on-read.
- Simultaneous events:
  - Tick and mtimecmp write in the same cycle: both apply.
  - Interrupt follows the combined result.
- Reset mid-operation: all state returns to reset values immediately; any pending read response is dropped (bus_rvalid=0).

Decomposition:
- Shared package riscv_periph_pkg holds:
  - register offset constants (MTIME_LO=2'd0, MTIME_HI=2'd1, MTIMECMP_LO=2'd2, MTIMECMP_HI=2'd3);
  - the BASE_ADDR default;
  - the 64-bit timer width constant.
- One natural sub-module, timer_prescaler: pcnt and tick generation, parameterised by PRESCALE.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> timer_interrupt=0, bus_rvalid=0; read offset 2 -> FFFF_FFFF one cycle later; read offset 0 after 10 cycles with PRESCALE=1 -> value 10 ±1 for access timing, exact value checked against a reference model.
- Carry and wrap:
  - write mtime_lo=FFFF_FFFE, mtime_hi=0; after 2 ticks -> hi=1, lo=0;
  - write hi=lo=FFFF_FFFF; after 1 tick -> both read 0.
- Interrupt:
  - mtimecmp={0,100}, mtime=90 -> interrupt rises when mtime reads 100 and stays high;
  - write mtimecmp_lo=200 -> interrupt low 1 cycle later.
- Collision: write mtime_lo=5 in a tick cycle -> reads 5, not 6, and hi is unchanged; a simultaneous tick and mtimecmp write match the reference model.
- Prescaler: PRESCALE=4 -> mtime increments exactly every 4th cycle; 40 cycles gives +10.
- Mid-operation reset: assert rst during a read and while interrupt=1 -> bus_rvalid and timer_interrupt drop asynchronously; all registers read their reset values afterwards.

Source files
------------

// File: rtl/riscv_periph_pkg.sv
// Shared constants for the core's memory-mapped peripherals:
// timer register offsets, default base address and counter width.
package riscv_periph_pkg;

    localparam logic [1:0]  MTIME_LO        = 2'd0;
    localparam logic [1:0]  MTIME_HI        = 2'd1;
    localparam logic [1:0]  MTIMECMP_LO     = 2'd2;
    localparam logic [1:0]  MTIMECMP_HI     = 2'd3;

    localparam logic [31:0] TIMER_BASE_ADDR = 32'h0200_4000;
    localparam int          TIMER_W         = 64;

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE cycles.
// Ports: clk, rst (async active-low), o_tick (high when pcnt == PRESCALE-1).
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_pcnt;

    assign o_tick = (r_pcnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
        end else if (o_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on the data bus, level irq.
// Ports: clk, rst (async active-low), bus_sel/we/addr/wdata in,
//        bus_rdata/bus_rvalid read response, timer_interrupt out.
module machine_timer
    import riscv_periph_pkg::*;
#(
    parameter logic [31:0]        BASE_ADDR = TIMER_BASE_ADDR,
    parameter int unsigned        PRESCALE  = 1,
    parameter logic [TIMER_W-1:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic        timer_interrupt
);

    logic [TIMER_W-1:0] r_time;
    logic [TIMER_W-1:0] r_cmp;
    logic [31:0]        r_rdata;
    logic               r_rvalid;
    logic               r_irq;

    logic               w_tick;
    logic               w_wr;
    logic               w_rd;
    logic [1:0]         w_off;
    logic [TIMER_W-1:0] w_time_nxt;
    logic [TIMER_W-1:0] w_cmp_nxt;
    logic [31:0]        w_rmux;

    // Range decode happens upstream; only the word offset matters here.
    logic w_unused;
    assign w_unused = ^{BASE_ADDR, bus_addr[31:4], bus_addr[1:0]};

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    assign w_off = bus_addr[3:2];
    assign w_wr  = bus_sel & bus_we;
    assign w_rd  = bus_sel & ~bus_we;

    // A software write to either mtime half overrides the tick entirely.
    always_comb begin
        w_time_nxt = r_time;
        w_cmp_nxt  = r_cmp;
        if (w_tick) begin
            w_time_nxt = r_time + 64'd1;
        end
        if (w_wr) begin
            unique case (w_off)
                MTIME_LO:    w_time_nxt = {r_time[63:32], bus_wdata};
                MTIME_HI:    w_time_nxt = {bus_wdata, r_time[31:0]};
                MTIMECMP_LO: w_cmp_nxt  = {r_cmp[63:32], bus_wdata};
                MTIMECMP_HI: w_cmp_nxt  = {bus_wdata, r_cmp[31:0]};
            endcase
        end
    end

    always_comb begin
        w_rmux = '0;
        unique case (w_off)
            MTIME_LO:    w_rmux = r_time[31:0];
            MTIME_HI:    w_rmux = r_time[63:32];
            MTIMECMP_LO: w_rmux = r_cmp[31:0];
            MTIMECMP_HI: w_rmux = r_cmp[63:32];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_time   <= '0;
            r_cmp    <= RESET_CMP;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_time   <= w_time_nxt;
            r_cmp    <= w_cmp_nxt;
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rmux;
            end
            // Compare post-update values so irq tracks the visible mtime.
            r_irq    <= (w_time_nxt >= w_cmp_nxt);
        end
    end

    assign bus_rdata       = r_rdata;
    assign bus_rvalid      = r_rvalid;
    assign timer_interrupt = r_irq;

endmodule

// File: tb/tb_machine_timer.sv
// Randomised and directed bench for machine_timer (PRESCALE 1 and 4)
// against a cycle-count reference model.
module tb_machine_timer;
    import riscv_periph_pkg::*;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        bus_sel   = 1'b0;
    logic        bus_we    = 1'b0;
    logic [31:0] bus_addr  = TIMER_BASE_ADDR;
    logic [31:0] bus_wdata = '0;
    logic [31:0] rdata1, rdata4;
    logic        rvalid1, rvalid4, irq1, irq4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    machine_timer #(.PRESCALE(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus_sel         (bus_sel),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (rdata1),
        .bus_rvalid      (rvalid1),
        .timer_interrupt (irq1)
    );

    machine_timer #(.PRESCALE(4)) dut4 (
        .clk             (clk),
        .rst             (rst),
        .bus_sel         (bus_sel),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (rdata4),
        .bus_rvalid      (rvalid4),
        .timer_interrupt (irq4)
    );

    // Reference state: index 0 -> PRESCALE=1, index 1 -> PRESCALE=4.
    longint unsigned m_time[2];
    longint unsigned m_cmp[2];
    longint unsigned m_cyc[2];
    longint unsigned m_pre[2] = '{1, 4};
    logic [31:0]     e_rdata[2];
    logic            e_rvalid[2];
    logic            e_irq[2];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_time[k]   = 0;
            m_cmp[k]    = 64'hFFFF_FFFF_FFFF_FFFF;
            m_cyc[k]    = 0;
            e_rdata[k]  = '0;
            e_rvalid[k] = 1'b0;
            e_irq[k]    = 1'b0;
        end
    endtask

    function automatic logic [31:0] reg_val(int k, logic [1:0] off);
        case (off)
            MTIME_LO:    return m_time[k][31:0];
            MTIME_HI:    return m_time[k][63:32];
            MTIMECMP_LO: return m_cmp[k][31:0];
            default:     return m_cmp[k][63:32];
        endcase
    endfunction

    // One clock edge of the model: every PRESCALE-th cycle since reset
    // is a tick; a write to an mtime half replaces the ticked value.
    task automatic model_edge();
        longint unsigned t, c;
        logic [1:0] off;
        off = bus_addr[3:2];
        for (int k = 0; k < 2; k++) begin
            m_cyc[k] = m_cyc[k] + 1;
            t = m_time[k];
            c = m_cmp[k];
            if (m_cyc[k] % m_pre[k] == 0) t = t + 1;
            e_rvalid[k] = bus_sel && !bus_we;
            if (e_rvalid[k]) e_rdata[k] = reg_val(k, off);
            if (bus_sel && bus_we) begin
                case (off)
                    MTIME_LO:    t = {m_time[k][63:32], bus_wdata};
                    MTIME_HI:    t = {bus_wdata, m_time[k][31:0]};
                    MTIMECMP_LO: c = {m_cmp[k][63:32], bus_wdata};
                    default:     c = {bus_wdata, m_cmp[k][31:0]};
                endcase
            end
            m_time[k] = t;
            m_cmp[k]  = c;
            e_irq[k]  = (t >= c);
        end
    endtask

    task automatic check_outputs();
        check("irq_p1",    irq1,    e_irq[0]);
        check("rvalid_p1", rvalid1, e_rvalid[0]);
        check("rdata_p1",  rdata1,  e_rdata[0]);
        check("irq_p4",    irq4,    e_irq[1]);
        check("rvalid_p4", rvalid4, e_rvalid[1]);
        check("rdata_p4",  rdata4,  e_rdata[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        if (rst) check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_addr(input logic [1:0] off);
        logic [1:0] lo;
        lo = 2'($urandom_range(0, 3));
        bus_addr = {TIMER_BASE_ADDR[31:4], off, lo};
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        bus_sel   = 1'b1;
        bus_we    = 1'b1;
        bus_wdata = d;
        set_addr(off);
        step();
        bus_sel = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] off,
                      output logic [31:0] d1, output logic [31:0] d4);
        bus_sel = 1'b1;
        bus_we  = 1'b0;
        set_addr(off);
        step();
        bus_sel = 1'b0;
        d1 = rdata1;
        d4 = rdata4;
    endtask

    logic [31:0] d1, d4, v0, v1, data;
    logic [1:0]  off;
    int          r;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_irq",    irq1,    1'b0);
        check("rst_rvalid", rvalid1, 1'b0);
        check("rst_rdata",  rdata1,  32'h0);
        rst = 1'b1;

        rd(MTIMECMP_LO, d1, d4);
        check("cmp_lo_reset", d1, 32'hFFFF_FFFF);
        idle(9);
        rd(MTIME_LO, d1, d4);
        check("mtime_after10_p1", d1, 32'd10);
        check("mtime_after10_p4", d4, 32'd2);

        wr(MTIME_LO, 32'hFFFF_FFFE);
        wr(MTIME_HI, 32'h0);
        idle(2);
        rd(MTIME_LO, d1, d4);
        check("carry_lo", d1, 32'h0);
        rd(MTIME_HI, d1, d4);
        check("carry_hi", d1, 32'h1);

        wr(MTIME_HI, 32'hFFFF_FFFF);
        wr(MTIME_LO, 32'hFFFF_FFFF);
        idle(1);
        rd(MTIME_LO, d1, d4);
        check("wrap_lo", d1, 32'h0);
        rd(MTIME_HI, d1, d4);
        check("wrap_hi", d1, 32'h0);

        wr(MTIMECMP_LO, 32'd100);
        wr(MTIMECMP_HI, 32'h0);
        wr(MTIME_HI, 32'h0);
        wr(MTIME_LO, 32'd90);
        check("irq_at90", irq1, 1'b0);
        idle(9);
        check("irq_at99", irq1, 1'b0);
        idle(1);
        check("irq_at100", irq1, 1'b1);
        rd(MTIME_LO, d1, d4);
        check("mtime_at_irq", d1, 32'd100);
        idle(5);
        check("irq_holds", irq1, 1'b1);
        wr(MTIMECMP_LO, 32'd200);
        check("irq_cleared", irq1, 1'b0);

        wr(MTIME_LO, 32'd5);
        rd(MTIME_LO, d1, d4);
        check("collide_lo_p1", d1, 32'd5);
        check("collide_lo_p4", d4, 32'd5);
        rd(MTIME_HI, d1, d4);
        check("collide_hi", d1, 32'h0);

        wr(MTIMECMP_LO, m_time[0][31:0] + 32'd1);
        check("tick_cmp_hit", irq1, 1'b1);
        wr(MTIMECMP_LO, m_time[0][31:0] + 32'd3);
        check("tick_cmp_miss", irq1, 1'b0);

        rd(MTIME_LO, d1, v0);
        idle(39);
        rd(MTIME_LO, d1, v1);
        check("prescale4_delta", v1 - v0, 32'd10);

        repeat (400) begin
            r   = $urandom_range(0, 3);
            off = 2'($urandom_range(0, 3));
            if (r == 0) begin
                idle(1);
            end else if (r == 1) begin
                rd(off, d1, d4);
            end else begin
                if (off == MTIME_HI || off == MTIMECMP_HI)
                    data = m_time[0][63:32];
                else
                    data = m_time[0][31:0] + 32'($urandom_range(0, 40));
                if ($urandom_range(0, 7) == 0) data = $urandom;
                wr(off, data);
            end
        end

        wr(MTIME_HI, 32'h0);
        wr(MTIMECMP_HI, 32'h0);
        wr(MTIMECMP_LO, 32'h0);
        check("pre_rst_irq", irq1, 1'b1);
        bus_sel = 1'b1;
        bus_we  = 1'b0;
        set_addr(MTIME_LO);
        @(posedge clk);
        #1;
        check("pre_rst_rvalid", rvalid1, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_rvalid_p1", rvalid1, 1'b0);
        check("mid_rst_irq_p1",    irq1,    1'b0);
        check("mid_rst_rvalid_p4", rvalid4, 1'b0);
        check("mid_rst_irq_p4",    irq4,    1'b0);
        check("mid_rst_rdata",     rdata1,  32'h0);
        model_reset();
        bus_sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd(MTIME_LO, d1, d4);
        check("post_rst_lo", d1, 32'h0);
        rd(MTIME_HI, d1, d4);
        check("post_rst_hi", d1, 32'h0);
        rd(MTIMECMP_LO, d1, d4);
        check("post_rst_cmp_lo", d1, 32'hFFFF_FFFF);
        rd(MTIMECMP_HI, d1, d4);
        check("post_rst_cmp_hi", d1, 32'hFFFF_FFFF);
        check("post_rst_cmp_hi_p4", d4, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
